uart_rx_packer: RTL and testbench

Parametrised UART receive front-end for the matmul system. It deserialises a configurable number of UART words and packs them into one wide bus beat with a valid/ready handshake, ready for the MVM core's K/X input.
It generalises the fixed 8N1 receiver with optional parity, 1 or 2 stop bits, start-glitch rejection, partial-packet timeout, and error/overflow reporting.
It sits between the chip rx pin (ui_in[0]) and the MVM input register.

---
 rtl/uart_rx_packer.sv | 155 +++++++++++++++
 tb/tb_uart_rx_packer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packer.sv
// UART receive front-end: deserialises BITS_PER_WORD-bit words and packs N_WORDS of
// them into one valid/ready beat, reporting framing, parity, overflow and timeout events.
module uart_rx_packer #(
  parameter int CLOCKS_PER_PULSE = 33,
  parameter int BITS_PER_WORD    = 8,
  parameter int N_WORDS          = 2,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1,
  parameter int TIMEOUT_PULSES   = 20
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             rx,
  output logic [N_WORDS*BITS_PER_WORD-1:0] m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             frame_err,
  output logic                             parity_err,
  output logic                             overflow,
  output logic                             timeout
);
  localparam int CW    = $clog2(CLOCKS_PER_PULSE);
  localparam int HALF  = CLOCKS_PER_PULSE / 2;
  localparam int BW    = $clog2(BITS_PER_WORD);
  localparam int WW    = $clog2(N_WORDS + 1);
  localparam int LIMIT = TIMEOUT_PULSES * CLOCKS_PER_PULSE;
  localparam int TW    = $clog2(LIMIT + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t                                state_q, state_d;
  logic [1:0]                            rx_sync;
  logic                                  rx_s;
  logic [CW-1:0]                         cnt;
  logic [BW-1:0]                         bit_idx;
  logic                                  stop_idx;
  logic [BITS_PER_WORD-1:0]              shreg;
  logic                                  par_bad;
  logic [WW-1:0]                         wcnt;
  logic [TW-1:0]                         idle_cnt;
  logic [N_WORDS-1:0][BITS_PER_WORD-1:0] asm_q;
  logic                                  mid, par_calc, pkt_full;
  logic                                  word_done, frame_hit, par_hit, to_hit;

  // Preset to idle-high so a reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) rx_sync <= 2'b11;
    else       rx_sync <= {rx_sync[0], rx};

  assign rx_s     = rx_sync[1];
  assign mid      = (cnt == CW'(HALF));
  assign par_calc = ^{shreg, rx_s};
  assign pkt_full = (wcnt == WW'(N_WORDS));
  assign to_hit   = (TIMEOUT_PULSES != 0) && (state_q == S_IDLE) && rx_s &&
                    (wcnt != '0) && (idle_cnt == TW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;

  always_comb begin
    state_d   = state_q;
    word_done = 1'b0;
    frame_hit = 1'b0;
    par_hit   = 1'b0;
    case (state_q)
      S_IDLE:      if (!rx_s) state_d = S_START;
      S_START:     if (mid) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (mid && bit_idx == BW'(BITS_PER_WORD - 1))
                     state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:    if (mid) begin
                     state_d = S_STOP;
                     par_hit = (PARITY == 1) ? ~par_calc : par_calc;
                   end
      S_STOP:      if (mid) begin
                     if (!rx_s) begin
                       state_d   = S_WAIT_HIGH;
                       frame_hit = 1'b1;
                     end else if (stop_idx == 1'(STOP_BITS - 1)) begin
                       state_d   = S_IDLE;
                       word_done = !par_bad;
                     end
                   end
      S_WAIT_HIGH: if (rx_s) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Bit timing restarts from zero at each start detection.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bad  <= 1'b0;
    end else begin
      if (state_q == S_IDLE || state_q == S_WAIT_HIGH) cnt <= '0;
      else if (cnt == CW'(CLOCKS_PER_PULSE - 1))       cnt <= '0;
      else                                             cnt <= cnt + CW'(1);

      if (state_q != S_DATA) bit_idx <= '0;
      else if (mid)          bit_idx <= bit_idx + BW'(1);

      if (state_q != S_STOP) stop_idx <= 1'b0;
      else if (mid)          stop_idx <= ~stop_idx;

      if (state_q == S_DATA && mid) shreg <= {rx_s, shreg[BITS_PER_WORD-1:1]};

      if (state_q == S_IDLE) par_bad <= 1'b0;
      else if (par_hit)      par_bad <= 1'b1;
    end

  // A full assembly buffer is handed off (or dropped) one cycle after the last word lands.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wcnt     <= '0;
      idle_cnt <= '0;
      asm_q    <= '0;
    end else begin
      if (pkt_full)                            wcnt <= '0;
      else if (par_hit || frame_hit || to_hit) wcnt <= '0;
      else if (word_done)                      wcnt <= wcnt + WW'(1);

      if (state_q != S_IDLE || !rx_s || wcnt == '0 || to_hit) idle_cnt <= '0;
      else                                                    idle_cnt <= idle_cnt + TW'(1);

      for (int iw = 0; iw < N_WORDS; iw++)
        if (word_done && wcnt == WW'(iw)) asm_q[iw] <= shreg;
    end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (pkt_full && (!m_valid || m_ready)) begin
        m_data  <= asm_q;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      frame_err  <= frame_hit;
      parity_err <= par_hit;
      overflow   <= pkt_full && m_valid && !m_ready;
      timeout    <= to_hit;
    end

endmodule

// File: tb/tb_uart_rx_packer.sv
// Bench for uart_rx_packer: three parameterisations, each fed from its own rx line,
// beats checked against per-instance expectation queues, error pulses counted per cycle.
module tb_uart_rx_packer;
  localparam int CPP = 33;
  // sync (2) + start detect (1) + start..stop mid (9*CPP+CPP/2) + sample edge (1) + load (1)
  localparam int LAT = 2 + 1 + 9 * CPP + CPP / 2 + 1 + 1;

  logic clk, rstn, line;
  int   sel;
  logic rx0, rx1, rx2;
  logic rdy0, rdy1, rdy2;
  logic [15:0] m_data0, m_data1;
  logic [23:0] m_data2;
  logic m_valid0, m_valid1, m_valid2;
  logic frame_err0, parity_err0, overflow0, timeout0;
  logic frame_err1, parity_err1, overflow1, timeout1;
  logic frame_err2, parity_err2, overflow2, timeout2;

  int n_vec, n_bad, cyc, t_last_start, rise_cyc0;
  logic v0_prev;
  int fe[3], pe[3], ov[3], tmo[3];
  logic [23:0] q0[$], q1[$], q2[$];

  typedef struct {
    logic [7:0]  w0, w1;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[5];

  assign rx0 = (sel == 0) ? line : 1'b1;
  assign rx1 = (sel == 1) ? line : 1'b1;
  assign rx2 = (sel == 2) ? line : 1'b1;

  uart_rx_packer u0 (
    .clk(clk), .rstn(rstn), .rx(rx0), .m_data(m_data0), .m_valid(m_valid0),
    .m_ready(rdy0), .frame_err(frame_err0), .parity_err(parity_err0),
    .overflow(overflow0), .timeout(timeout0));

  uart_rx_packer #(.PARITY(2)) u1 (
    .clk(clk), .rstn(rstn), .rx(rx1), .m_data(m_data1), .m_valid(m_valid1),
    .m_ready(rdy1), .frame_err(frame_err1), .parity_err(parity_err1),
    .overflow(overflow1), .timeout(timeout1));

  uart_rx_packer #(.N_WORDS(3), .STOP_BITS(2)) u2 (
    .clk(clk), .rstn(rstn), .rx(rx2), .m_data(m_data2), .m_valid(m_valid2),
    .m_ready(rdy2), .frame_err(frame_err2), .parity_err(parity_err2),
    .overflow(overflow2), .timeout(timeout2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic got_beat(input int d, input logic [23:0] got);
    logic [23:0] exp;
    bit have;
    have = 1'b0;
    exp  = '0;
    case (d)
      0: if (q0.size() > 0) begin exp = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin exp = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin exp = q2.pop_front(); have = 1'b1; end
    endcase
    if (have) chk($sformatf("beat%0d", d), 32'(got), 32'(exp));
    else begin
      n_vec++;
      n_bad++;
      $display("FAIL beat%0d unexpected: got %h expected no beat", d, got);
    end
  endtask

  // Inspects the pre-edge state, so a sampled valid&&ready is exactly a handshake.
  task automatic monitor();
    if (m_valid0 && !v0_prev) rise_cyc0 = cyc;
    v0_prev = m_valid0;
    if (m_valid0 && rdy0) got_beat(0, 24'(m_data0));
    if (m_valid1 && rdy1) got_beat(1, 24'(m_data1));
    if (m_valid2 && rdy2) got_beat(2, m_data2);
    fe[0] += int'(frame_err0);  pe[0] += int'(parity_err0);
    ov[0] += int'(overflow0);   tmo[0] += int'(timeout0);
    fe[1] += int'(frame_err1);  pe[1] += int'(parity_err1);
    ov[1] += int'(overflow1);   tmo[1] += int'(timeout1);
    fe[2] += int'(frame_err2);  pe[2] += int'(parity_err2);
    ov[2] += int'(overflow2);   tmo[2] += int'(timeout2);
  endtask

  task automatic tick();
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 3; i++) begin
      fe[i] = 0; pe[i] = 0; ov[i] = 0; tmo[i] = 0;
    end
  endtask

  task automatic chk_counts(input string tag, input int d, input int efe, input int epe,
                            input int eov, input int eto);
    chk({tag, " frame_err"},  32'(fe[d]),  32'(efe));
    chk({tag, " parity_err"}, 32'(pe[d]),  32'(epe));
    chk({tag, " overflow"},   32'(ov[d]),  32'(eov));
    chk({tag, " timeout"},    32'(tmo[d]), 32'(eto));
  endtask

  task automatic send_bit(input logic b);
    line = b;
    repeat (CPP) tick();
  endtask

  // par < 0 sends no parity bit; otherwise par[0] is sent as the parity bit.
  task automatic send_word(input int d, input logic [7:0] w, input int par,
                           input int nstop, input logic stop_v);
    sel = d;
    t_last_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    if (par >= 0) send_bit(par[0]);
    for (int i = 0; i < nstop; i++) send_bit(stop_v);
  endtask

  initial begin
    logic [7:0] rw0, rw1, rw2;
    logic stable;
    n_vec = 0; n_bad = 0; cyc = 0; t_last_start = 0; rise_cyc0 = -1;
    v0_prev = 1'b0;
    line = 1'b1; sel = 0; rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    clr_counts();

    tbl[0] = '{w0: 8'h3C, w1: 8'hA5, exp: 16'hA53C};
    tbl[1] = '{w0: 8'h00, w1: 8'hFF, exp: 16'hFF00};
    tbl[2] = '{w0: 8'hFF, w1: 8'h00, exp: 16'h00FF};
    tbl[3] = '{w0: 8'h01, w1: 8'h80, exp: 16'h8001};
    tbl[4] = '{w0: 8'hAA, w1: 8'h55, exp: 16'h55AA};

    rstn = 1'b0;
    #1;
    idle(3);
    chk("reset m_valid", 32'({m_valid0, m_valid1, m_valid2}), 32'd0);
    chk("reset m_data", 32'(m_data0 | m_data1 | m_data2[15:0] | {8'h0, m_data2[23:16]}), 32'd0);
    chk("reset pulses", 32'({frame_err0, parity_err0, overflow0, timeout0}), 32'd0);
    rstn = 1'b1;
    idle(10);

    // Good packets on the default instance, ready held high.
    clr_counts();
    for (int i = 0; i < 5; i++) begin
      q0.push_back(24'(tbl[i].exp));
      send_word(0, tbl[i].w0, -1, 1, 1'b1);
      send_word(0, tbl[i].w1, -1, 1, 1'b1);
      idle(10);
    end
    chk_counts("table", 0, 0, 0, 0, 0);

    // Latency and hold under backpressure.
    rdy0 = 1'b0;
    q0.push_back(24'h00A53C);
    send_word(0, 8'h3C, -1, 1, 1'b1);
    send_word(0, 8'hA5, -1, 1, 1'b1);
    chk("latency", 32'(rise_cyc0 - t_last_start), 32'(LAT));
    stable = 1'b1;
    repeat (50) begin
      if (m_data0 !== 16'hA53C || m_valid0 !== 1'b1) stable = 1'b0;
      tick();
    end
    chk("hold stable", 32'(stable), 32'd1);
    rdy0 = 1'b1;
    tick();
    chk("valid drop after ready", 32'(m_valid0), 32'd0);

    // Start glitch, then a normal packet.
    clr_counts();
    sel = 0;
    line = 1'b0;
    idle(10);
    line = 1'b1;
    idle(60);
    q0.push_back(24'h00A53C);
    send_word(0, 8'h3C, -1, 1, 1'b1);
    send_word(0, 8'hA5, -1, 1, 1'b1);
    idle(10);
    chk_counts("glitch", 0, 0, 0, 0, 0);

    // Frame error with the line stuck low afterwards.
    clr_counts();
    send_word(0, 8'h55, -1, 1, 1'b0);
    idle(100);
    line = 1'b1;
    idle(2 * CPP);
    q0.push_back(24'h000201);
    send_word(0, 8'h01, -1, 1, 1'b1);
    send_word(0, 8'h02, -1, 1, 1'b1);
    idle(10);
    chk_counts("frame", 0, 1, 0, 0, 0);

    // Even parity: bad parity drops the word, then a clean packet.
    clr_counts();
    send_word(1, 8'h07, 0, 1, 1'b1);
    q1.push_back(24'h008007);
    send_word(1, 8'h07, 1, 1, 1'b1);
    send_word(1, 8'h80, 1, 1, 1'b1);
    idle(10);
    chk_counts("parity", 1, 0, 1, 0, 0);

    // Overflow: second packet arrives while the first is still held.
    clr_counts();
    rdy0 = 1'b0;
    q0.push_back(24'h002211);
    send_word(0, 8'h11, -1, 1, 1'b1);
    send_word(0, 8'h22, -1, 1, 1'b1);
    send_word(0, 8'h33, -1, 1, 1'b1);
    send_word(0, 8'h44, -1, 1, 1'b1);
    idle(10);
    chk("overflow held data", 32'(m_data0), 32'h2211);
    rdy0 = 1'b1;
    idle(3 * CPP);
    chk_counts("overflow", 0, 0, 0, 1, 0);

    // Partial-packet timeout.
    clr_counts();
    send_word(0, 8'h99, -1, 1, 1'b1);
    idle(20 * CPP + 5);
    chk_counts("timeout", 0, 0, 0, 0, 1);
    q0.push_back(24'h000201);
    send_word(0, 8'h01, -1, 1, 1'b1);
    send_word(0, 8'h02, -1, 1, 1'b1);
    idle(10);
    chk("timeout no repeat", 32'(tmo[0]), 32'd1);

    // Random packets, three words and two stop bits.
    for (int p = 0; p < 10; p++) begin
      rw0 = 8'($urandom_range(255, 0));
      rw1 = 8'($urandom_range(255, 0));
      rw2 = 8'($urandom_range(255, 0));
      q2.push_back({rw2, rw1, rw0});
      send_word(2, rw0, -1, 2, 1'b1);
      send_word(2, rw1, -1, 2, 1'b1);
      send_word(2, rw2, -1, 2, 1'b1);
      idle(5 + int'($urandom_range(40, 0)));
    end
    chk_counts("random", 2, 0, 0, 0, 0);

    // Reset with a held beat and a word in flight.
    clr_counts();
    rdy0 = 1'b0;
    send_word(0, 8'h12, -1, 1, 1'b1);
    send_word(0, 8'h34, -1, 1, 1'b1);
    idle(10);
    chk("held before reset", 32'(m_valid0), 32'd1);
    sel = 0;
    line = 1'b0;
    idle(3 * CPP);
    rstn = 1'b0;
    line = 1'b1;
    idle(3);
    chk("mid-word reset valid", 32'(m_valid0), 32'd0);
    chk("mid-word reset data", 32'(m_data0), 32'd0);
    chk("mid-word reset pulses", 32'({frame_err0, parity_err0, overflow0, timeout0}), 32'd0);
    rstn = 1'b1;
    rdy0 = 1'b1;
    idle(22 * CPP);
    chk_counts("post reset", 0, 0, 0, 0, 0);

    chk("q0 drained", 32'(q0.size()), 32'd0);
    chk("q1 drained", 32'(q1.size()), 32'd0);
    chk("q2 drained", 32'(q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
